// File: rtl/gpu_pkg.sv
// Shared GPU raster-path definitions: coordinate width and the line-engine state type.
package gpu_pkg;

    localparam int unsigned GPU_COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } bla_state_t;

endpackage

// File: rtl/bla_setup.sv
// Bresenham setup: derives deltas, step directions and initial error from latched endpoints.
//   x0,y0,x1,y1 : latched endpoints (unsigned)
//   dx          : |x1-x0| (signed, COORD_W+2 bits)
//   dy          : -|y1-y0| (signed, COORD_W+2 bits)
//   err         : dx+dy, initial error term
//   x_neg,y_neg : step direction is -1 on that axis
module bla_setup
    import gpu_pkg::*;
#(
    parameter int unsigned COORD_W = GPU_COORD_W
) (
    input  logic [COORD_W-1:0]        x0,
    input  logic [COORD_W-1:0]        y0,
    input  logic [COORD_W-1:0]        x1,
    input  logic [COORD_W-1:0]        y1,
    output logic signed [COORD_W+1:0] dx,
    output logic signed [COORD_W+1:0] dy,
    output logic signed [COORD_W+1:0] err,
    output logic                      x_neg,
    output logic                      y_neg
);

    logic [COORD_W-1:0] adx;
    logic [COORD_W-1:0] ady;

    // Direction is -1 whenever start is not strictly below end; with a zero delta it never steps.
    always_comb begin
        x_neg = !(x0 < x1);
        y_neg = !(y0 < y1);
        adx   = x_neg ? (x0 - x1) : (x1 - x0);
        ady   = y_neg ? (y0 - y1) : (y1 - y0);
        dx    = $signed({2'b00, adx});
        dy    = -$signed({2'b00, ady});
        err   = dx + dy;
    end

endmodule

// File: rtl/bla_engine.sv
// Bresenham line-drawing engine: walks every pixel from (x0,y0) to (x1,y1) and streams
// coordinates under a valid/ready handshake.
//   clk, n_rst      : clock, async active-low reset
//   bla_en          : level enable; sampled high in IDLE starts a line, low aborts/re-arms
//   x0,y0,x1,y1     : endpoints, latched on start
//   pix_ready       : downstream accepts the current pixel
//   pix_valid       : pix_x/pix_y hold a pixel (registered)
//   pix_x, pix_y    : current pixel coordinate (registered)
//   bla_done        : line complete, held until bla_en drops (registered)
//   busy            : engine not in IDLE (registered)
module bla_engine
    import gpu_pkg::*;
#(
    parameter int unsigned COORD_W = GPU_COORD_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               bla_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               bla_done,
    output logic               busy
);

    localparam int unsigned SW = COORD_W + 2;

    bla_state_t state;
    bla_state_t state_next;

    logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
    logic signed [SW-1:0] dx, dy, err;
    logic x_neg, y_neg;

    logic signed [SW-1:0] s_dx, s_dy, s_err;
    logic s_x_neg, s_y_neg;

    logic signed [SW-1:0] e2;
    logic step_x, step_y, at_end;
    logic capture, step_en;

    bla_setup #(.COORD_W(COORD_W)) u_setup (
        .x0    (lx0),
        .y0    (ly0),
        .x1    (lx1),
        .y1    (ly1),
        .dx    (s_dx),
        .dy    (s_dy),
        .err   (s_err),
        .x_neg (s_x_neg),
        .y_neg (s_y_neg)
    );

    // Both axis decisions use the same pre-step e2 so diagonal moves happen in one cycle.
    always_comb begin
        e2     = err <<< 1;
        step_x = (e2 >= dy);
        step_y = (e2 <= dx);
        at_end = (pix_x == lx1) && (pix_y == ly1);
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables; dropping bla_en anywhere but IDLE returns to IDLE.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bla_en) begin
                    capture    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = bla_en ? DRAW : IDLE;
            end
            DRAW: begin
                if (!bla_en) begin
                    state_next = IDLE;
                end else if (pix_ready) begin
                    if (at_end) begin
                        state_next = DONE;
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!bla_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: endpoint latch, setup load, Bresenham step.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lx0   <= '0;
            ly0   <= '0;
            lx1   <= '0;
            ly1   <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
        end else begin
            if (capture) begin
                lx0 <= x0;
                ly0 <= y0;
                lx1 <= x1;
                ly1 <= y1;
            end
            if (state == LOAD) begin
                dx    <= s_dx;
                dy    <= s_dy;
                err   <= s_err;
                x_neg <= s_x_neg;
                y_neg <= s_y_neg;
                pix_x <= lx0;
                pix_y <= ly0;
            end
            if (step_en) begin
                err <= err + (step_x ? dy : SW'(0)) + (step_y ? dx : SW'(0));
                if (step_x) begin
                    pix_x <= x_neg ? (pix_x - COORD_W'(1)) : (pix_x + COORD_W'(1));
                end
                if (step_y) begin
                    pix_y <= y_neg ? (pix_y - COORD_W'(1)) : (pix_y + COORD_W'(1));
                end
            end
        end
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_valid <= 1'b0;
            bla_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pix_valid <= (state_next == DRAW);
            bla_done  <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_bla_engine.sv
// Self-checking bench for bla_engine: directed test-plan lines plus random lines with random
// backpressure, checked against a plain-integer Bresenham reference and geometric invariants.
module tb_bla_engine;
    import gpu_pkg::*;

    localparam int unsigned CW = GPU_COORD_W;

    logic          clk;
    logic          n_rst;
    logic          bla_en;
    logic [CW-1:0] x0, y0, x1, y1;
    logic          pix_ready;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic          bla_done;
    logic          busy;

    int n_cmp;
    int n_err;
    int exp_q[$];

    bla_engine #(.COORD_W(CW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bla_en    (bla_en),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .bla_done  (bla_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference pixel list, encoded x*4096+y, built with plain integer arithmetic.
    task automatic build_ref(input int ax0, input int ay0, input int ax1, input int ay1);
        int ddx, ddy, sx, sy, e, e2, cx, cy;
        exp_q.delete();
        ddx = iabs(ax1 - ax0);
        ddy = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        e   = ddx + ddy;
        cx  = ax0;
        cy  = ay0;
        for (int guard = 0; guard < 5000; guard++) begin
            exp_q.push_back(cx * 4096 + cy);
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; cx += sx; end
            if (e2 <= ddx) begin e += ddx; cy += sy; end
        end
    endtask

    // Draw one full line; pct = pix_ready probability, stall_at = pixel index held 3 cycles.
    task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int pct, input int stall_at);
        int  npix, budget, cyc, got_n, stall, px, py, cx, cy, hx, hy;
        bit  hold;
        build_ref(ax0, ay0, ax1, ay1);
        npix   = imax(iabs(ax1 - ax0), iabs(ay1 - ay0)) + 1;
        budget = 20 * (npix + 5);
        @(negedge clk);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        bla_en    = 1'b1;
        pix_ready = 1'b0;
        @(negedge clk);
        check("load_valid", int'(pix_valid), 0);
        check("load_busy", int'(busy), 1);
        @(negedge clk);
        got_n = 0; stall = 0; cyc = 0; hold = 1'b0; px = -1; py = -1; hx = 0; hy = 0;
        while (exp_q.size() > 0) begin
            if (cyc > budget) begin
                check("timeout", 0, 1);
                break;
            end
            if (!pix_valid) begin
                check("valid_high", int'(pix_valid), 1);
                break;
            end
            cx = int'(pix_x);
            cy = int'(pix_y);
            if (hold) begin
                check("hold_x", cx, hx);
                check("hold_y", cy, hy);
            end
            if (got_n == stall_at && stall < 3) begin
                pix_ready = 1'b0;
                stall++;
            end else begin
                pix_ready = ($urandom_range(99) < pct);
            end
            if (pix_ready) begin
                check("pix", cx * 4096 + cy, exp_q.pop_front());
                check("bbox", int'(cx >= imax(0, (ax0 < ax1 ? ax0 : ax1)) && cx <= imax(ax0, ax1) &&
                                   cy >= (ay0 < ay1 ? ay0 : ay1) && cy <= imax(ay0, ay1)), 1);
                if (px >= 0)
                    check("adjacent", int'(iabs(cx - px) <= 1 && iabs(cy - py) <= 1 &&
                                           !(cx == px && cy == py)), 1);
                px = cx; py = cy;
                got_n++;
            end
            hold = !pix_ready;
            hx = cx; hy = cy;
            cyc++;
            @(negedge clk);
        end
        pix_ready = 1'($urandom_range(1));
        check("count", got_n, npix);
        check("done_rise", int'(bla_done), 1);
        check("valid_after", int'(pix_valid), 0);
        repeat (3) begin
            @(negedge clk);
            check("done_hold", int'(bla_done), 1);
            check("no_restart", int'(pix_valid), 0);
        end
        bla_en = 1'b0;
        @(negedge clk);
        check("rearm_done", int'(bla_done), 0);
        check("rearm_busy", int'(busy), 0);
    endtask

    // Start a line with ready high and let n pixels transfer.
    task automatic start_and_take(input int ax0, input int ay0, input int ax1, input int ay1,
                                  input int n);
        build_ref(ax0, ay0, ax1, ay1);
        @(negedge clk);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        bla_en    = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            check("part_valid", int'(pix_valid), 1);
            check("part_pix", int'(pix_x) * 4096 + int'(pix_y), exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, span;
        n_cmp = 0; n_err = 0;
        n_rst = 1'b0; bla_en = 1'b0; pix_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #12;
        check("rst_valid", int'(pix_valid), 0);
        check("rst_done", int'(bla_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_xy", int'(pix_x) + int'(pix_y), 0);
        @(negedge clk);
        n_rst = 1'b1;

        draw(0, 0, 4, 0, 100, -1);
        draw(2, 1, 3, 6, 100, -1);
        draw(5, 5, 0, 2, 100, -1);
        draw(7, 7, 7, 7, 100, -1);
        draw(0, 0, 3, 3, 100, 1);

        // Abort after the second pixel.
        start_and_take(0, 0, 9, 0, 2);
        bla_en    = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);
        check("abort_valid", int'(pix_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(bla_done), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", int'(pix_valid) + int'(bla_done), 0);
        end

        // Asynchronous reset mid-line, then a clean redraw.
        start_and_take(0, 0, 9, 9, 3);
        #2 n_rst = 1'b0;
        #1;
        check("arst_valid", int'(pix_valid), 0);
        check("arst_done", int'(bla_done), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_x", int'(pix_x), 0);
        check("arst_y", int'(pix_y), 0);
        bla_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        draw(3, 4, 8, 6, 100, -1);

        for (int t = 0; t < 20; t++) begin
            span = (t < 15) ? 63 : 1023;
            rx0 = $urandom_range(span); ry0 = $urandom_range(span);
            rx1 = $urandom_range(span); ry1 = $urandom_range(span);
            if (t >= 15 && span == 1023) begin
                rx0 = $urandom_range(200); ry0 = $urandom_range(200);
            end
            draw(rx0, ry0, rx1, ry1, 30 + $urandom_range(70), $urandom_range(4));
        end
        draw(0, 1023, 1023, 0, 90, -1);
        draw(1023, 1023, 0, 0, 100, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
